// File: rtl/lcd_responder.sv
// HD44780-style responder: synchronises the character-LCD bus, executes the writer's
// instruction subset and keeps a 32-entry display buffer with busy timing and a read port.
module lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [4:0] CURSOR,
  output logic       BUSY,
  output logic       ENTRY_INC,
  output logic       DISP_ON,
  output logic       FUNC_OK,
  output logic       WR_STROBE,
  output logic       CMD_ERR,
  output logic       OVERRUN
);

  localparam int MAX_CNT = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  // The sweep itself accounts for 32 of the clear's busy cycles.
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 32);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic       en_meta_r, en_sync_r, en_prev_r;
  logic       rs_meta_r, rs_sync_r;
  logic       rw_meta_r, rw_sync_r;
  logic [7:0] data_meta_r, data_sync_r;

  state_t        state_r;
  logic [4:0]    clr_idx_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic [4:0]    cursor_r;
  logic          entry_inc_r;
  logic          disp_on_r;
  logic          func_ok_r;
  logic          wr_strobe_r;
  logic          cmd_err_r;
  logic          overrun_r;
  logic [7:0]    rd_char_r;

  logic [7:0] mem_r [32];

  logic       fall_s;
  logic       accept_s;
  logic       reject_s;
  logic       mem_we_s;
  logic [4:0] mem_wa_s;
  logic [7:0] mem_wd_s;

  assign fall_s   = en_prev_r & ~en_sync_r;
  assign accept_s = fall_s & ~rw_sync_r & ~busy_r;
  assign reject_s = fall_s & ~rw_sync_r & busy_r;

  // Two-stage synchronisers for the bus plus EN history for edge detection.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      en_meta_r   <= 1'b0;
      en_sync_r   <= 1'b0;
      en_prev_r   <= 1'b0;
      rs_meta_r   <= 1'b0;
      rs_sync_r   <= 1'b0;
      rw_meta_r   <= 1'b0;
      rw_sync_r   <= 1'b0;
      data_meta_r <= 8'h00;
      data_sync_r <= 8'h00;
    end else begin
      en_meta_r   <= LCD_EN;
      en_sync_r   <= en_meta_r;
      en_prev_r   <= en_sync_r;
      rs_meta_r   <= LCD_RS;
      rs_sync_r   <= rs_meta_r;
      rw_meta_r   <= LCD_RW;
      rw_sync_r   <= rw_meta_r;
      data_meta_r <= LCD_DATA;
      data_sync_r <= data_meta_r;
    end
  end

  // Buffer write port: clear sweep has priority; data writes only when accepted.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = cursor_r;
    mem_wd_s = data_sync_r;
    if ((state_r == S_CLEAR) && RST) begin
      mem_we_s = 1'b1;
      mem_wa_s = clr_idx_r;
      mem_wd_s = 8'h20;
    end else if ((state_r == S_IDLE) && accept_s && rs_sync_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Display buffer storage; no reset, the clear sweep initialises it.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // Control FSM, instruction execution and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state_r     <= S_CLEAR;
      clr_idx_r   <= 5'd0;
      cnt_r       <= '0;
      busy_r      <= 1'b1;
      cursor_r    <= 5'd0;
      entry_inc_r <= 1'b1;
      disp_on_r   <= 1'b0;
      func_ok_r   <= 1'b0;
      wr_strobe_r <= 1'b0;
      cmd_err_r   <= 1'b0;
      overrun_r   <= 1'b0;
      rd_char_r   <= 8'h00;
    end else begin
      rd_char_r   <= mem_r[RD_ADDR];
      wr_strobe_r <= 1'b0;
      if (reject_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        S_CLEAR: begin
          clr_idx_r <= clr_idx_r + 5'd1;
          if (clr_idx_r == 5'd31) begin
            if (cnt_r == '0) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_r <= CW'(1)) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        S_IDLE: begin
          if (accept_s) begin
            busy_r  <= 1'b1;
            state_r <= S_WAIT;
            cnt_r   <= BUSY_LOAD;
            if (rs_sync_r) begin
              wr_strobe_r <= 1'b1;
              cursor_r    <= entry_inc_r ? (cursor_r + 5'd1) : (cursor_r - 5'd1);
            end else begin
              casez (data_sync_r)
                8'b1???_????: begin
                  if (data_sync_r[6:4] == 3'b000) begin
                    cursor_r <= {1'b0, data_sync_r[3:0]};
                  end else if (data_sync_r[6:4] == 3'b100) begin
                    cursor_r <= {1'b1, data_sync_r[3:0]};
                  end else begin
                    cmd_err_r <= 1'b1;
                  end
                end
                8'b01??_????: begin
                  cmd_err_r <= cmd_err_r;
                end
                8'b001?_????: begin
                  func_ok_r <= data_sync_r[4] & data_sync_r[3];
                  if (!(data_sync_r[4] & data_sync_r[3])) begin
                    cmd_err_r <= 1'b1;
                  end
                end
                8'b0001_????: begin
                  if (data_sync_r[3]) begin
                    cmd_err_r <= 1'b1;
                  end else begin
                    cursor_r <= data_sync_r[2] ? (cursor_r + 5'd1) : (cursor_r - 5'd1);
                  end
                end
                8'b0000_1???: begin
                  disp_on_r <= data_sync_r[2];
                end
                8'b0000_01??: begin
                  entry_inc_r <= data_sync_r[1];
                  if (data_sync_r[0]) begin
                    cmd_err_r <= 1'b1;
                  end
                end
                8'b0000_001?: begin
                  cursor_r <= 5'd0;
                end
                8'b0000_0001: begin
                  cursor_r    <= 5'd0;
                  entry_inc_r <= 1'b1;
                  state_r     <= S_CLEAR;
                  clr_idx_r   <= 5'd0;
                  cnt_r       <= CLEAR_LOAD;
                end
                default: begin
                  cmd_err_r <= 1'b1;
                end
              endcase
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign RD_CHAR   = rd_char_r;
  assign CURSOR    = cursor_r;
  assign BUSY      = busy_r;
  assign ENTRY_INC = entry_inc_r;
  assign DISP_ON   = disp_on_r;
  assign FUNC_OK   = func_ok_r;
  assign WR_STROBE = wr_strobe_r;
  assign CMD_ERR   = cmd_err_r;
  assign OVERRUN   = overrun_r;

endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Synthesizable HD44780-compatible responder on the 16x2 character-LCD bus, i.e. the receiving end of the LCD writer.
- Captures every strobe on LCD_EN/LCD_RS/LCD_RW/LCD_DATA and executes the instruction subset that the LCD writer issues.
- Maintains a 32-character display buffer with cursor and busy timing, plus a registered read port.
- Used in simulation and on-board loopback to check LCD output without a physical panel.

Parameters:
- BUSY_CYCLES, 2000, CLOCK_50 cycles BUSY stays high after any non-clear accepted transaction (40 us).
- CLEAR_CYCLES, 82000, CLOCK_50 cycles BUSY stays high after Clear Display (1.64 ms); must be >= 32.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous active-low reset.
- LCD_EN  in  1  bus enable strobe, asynchronous to CLOCK_50.
- LCD_RS  in  1  0 = instruction, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_DATA  in  8  bus data.
- RD_ADDR  in  5  buffer read index; 0-15 = line 1, 16-31 = line 2.
- RD_CHAR  out  8  buffer[RD_ADDR], registered.
- CURSOR  out  5  current write index.
- BUSY  out  1  responder executing; new strobes are rejected.
- ENTRY_INC  out  1  entry mode: 1 = increment, 0 = decrement.
- DISP_ON  out  1  display-on bit from Display Control.
- FUNC_OK  out  1  Function Set with DL=1, N=1 received.
- WR_STROBE  out  1  one-cycle pulse per accepted data write.
- CMD_ERR  out  1  sticky: unsupported or invalid instruction seen.
- OVERRUN  out  1  sticky: strobe arrived while BUSY.

Behaviour:
- Input capture
  - LCD_EN, LCD_RS, LCD_RW and LCD_DATA each pass through a 2-flop synchronizer; a third register on EN detects the falling edge.
  - The transaction fires on synchronized EN 1->0, using the synchronized RS/RW/DATA sampled in that same cycle.
  - LCD_RW=1: transaction ignored, no side effects, no BUSY.
- Busy rule
  - BUSY is a register. A fall detected while BUSY==1, including the final busy cycle, is rejected and sets OVERRUN. Buffer and cursor are untouched.
- State machine: S_CLEAR, S_IDLE, S_WAIT.
  - S_CLEAR: writes 0x20 to buffer[k] for k = 0..31, one entry per cycle, with BUSY=1. Then enters S_WAIT with the remaining count. Total BUSY time is CLEAR_CYCLES from entry, or exactly 32 cycles after reset.
  - S_IDLE: BUSY=0. On an accepted fall, the instruction executes in that cycle, then the FSM moves to S_WAIT (count BUSY_CYCLES) or S_CLEAR.
  - S_WAIT: down-counts to 1, then goes to S_IDLE.
- Instruction decode (RS=0), priority by highest set bit
  - 1AAAAAAA Set DDRAM: A = 0x00-0x0F sets CURSOR = A; A = 0x40-0x4F sets CURSOR = 16 + A[3:0]. Any other A sets CMD_ERR and leaves CURSOR unchanged.
  - 01xxxxxx Set CGRAM: ignored (BUSY still applied).
  - 001DNFxx Function Set: FUNC_OK <= (D & N); if either is 0, set CMD_ERR.
  - 0001SRxx Shift: S=0 moves CURSOR +1 if R=1, else -1, with 5-bit wrap. S=1 sets CMD_ERR and does nothing else.
  - 00001Dxx Display Control: DISP_ON <= D.
  - 000001IS Entry Mode: ENTRY_INC <= I; S=1 sets CMD_ERR.
  - 0000001x Return Home: CURSOR <= 0.
  - 00000001 Clear: CURSOR <= 0, ENTRY_INC <= 1, then S_CLEAR.
  - 00000000: CMD_ERR.
- Data (RS=1)
  - buffer[CURSOR] <= DATA; WR_STROBE pulses.
  - CURSOR moves ±1 per ENTRY_INC with 5-bit wrap (15->16, 31->0, 0->31).
  - Data writes are accepted regardless of FUNC_OK.
- Read port
  - RD_CHAR <= buffer[RD_ADDR] every cycle, 1-cycle latency.
  - A read of the entry being written in the same cycle returns the old value.
- Reset (RST=0, asynchronous, including mid-clear or mid-busy)
  - Outputs: RD_CHAR=0x00, CURSOR=0, BUSY=1, ENTRY_INC=1, DISP_ON=0, FUNC_OK=0, WR_STROBE=0, CMD_ERR=0, OVERRUN=0.
  - Synchronizers are cleared to 0.
  - After release, the FSM starts in S_CLEAR at index 0.

Test Plan:
- Reset release -> BUSY high exactly 32 cycles; then RD_ADDR=0..31 each return 0x20; CURSOR=0.
- Writer sequence 0x38, 0x06, 0x01, then "OUTPUT:" as data -> FUNC_OK=1, ENTRY_INC=1, buffer[0..6]="OUTPUT:", CURSOR=7, seven WR_STROBE pulses.
- Instruction 0xC0 then data 'P','C' -> buffer[16]='P', buffer[17]='C', CURSOR=18. Instruction 0x95 -> CMD_ERR=1, CURSOR stays 18.
- Entry mode 0x04, Set DDRAM 0x80, data 'X' -> buffer[0]='X', CURSOR=31. Data 'Y' at CURSOR=15 with ENTRY_INC=1 -> CURSOR=16.
- Strobe issued 10 cycles after a data write, with BUSY_CYCLES=2000 -> OVERRUN=1, buffer unchanged. Clear, then strobe at CLEAR_CYCLES-1 -> rejected.
- RST asserted mid-clear at index 12 -> all outputs at reset values immediately; after release, the full 32-entry sweep completes. LCD_RW=1 strobe -> no change.
